// File: rtl/uart_axi_buffer.sv
// uart_axi_buffer
//   AXI4-Lite slave that sits between the memory stage's UART window and the
//   serial UART core. Received bytes wait in an RX FIFO until the core side
//   reads them. Bytes written by the core side wait in a TX FIFO until the
//   transmitter takes them.
//
//   Register map (addr[3:0]):
//     0x0  RX data (read pops one byte)
//     0x4  TX data (write pushes wdata[7:0])
//     0x8  status  {TX full, TX empty, RX full, RX non-empty}
//   Other accesses get SLVERR with no side effects. A read of an empty RX
//   port, or a write to a full TX port, holds the response back until the
//   FIFO can serve it.
//
//   Ports:
//     clk, rstn          clock, asynchronous active-low reset
//     axi_ar*/axi_r*     AXI4-Lite read address / read data channels
//     axi_aw*/axi_w*/b*  AXI4-Lite write address / write data / response
//     rx_data/valid/rdy  byte stream from the UART receiver into the RX FIFO
//     tx_data/valid/rdy  byte stream from the TX FIFO to the UART transmitter
module uart_axi_buffer #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  // Only the low nibble of the addresses and the low byte of the write data
  // carry meaning; strobes are ignored.
  logic unused_ok;
  assign unused_ok = ^{axi_araddr[31:4], axi_awaddr[31:4], axi_wdata[31:8], axi_wstrb};

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_AW:0]   rx_cnt;
  logic             rx_empty, rx_full, rx_push, rx_pop;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_empty, tx_full, tx_push, tx_pop;

  r_state_t    r_state;
  logic [3:0]  r_addr;
  logic        r_go;
  logic [31:0] r_data_nxt;
  logic [1:0]  r_resp_nxt;
  logic [31:0] status;

  w_state_t    w_state;
  logic        aw_held, w_held;
  logic [3:0]  w_addr;
  logic [7:0]  w_byte;

  // RX FIFO: flags come from the registered count, so a bus pop in the same
  // cycle never lets a push into a full FIFO.
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULL_CNT);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && !rx_full;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RX_AW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RX_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // TX FIFO: the head is forced to zero while empty so tx_data is defined
  // even though the storage itself is never cleared.
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL_CNT);
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = (w_state == W_IDLE) && aw_held && w_held &&
                    (w_addr == ADDR_TX) && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= w_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TX_AW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TX_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Read side: the response is produced in the wait state only once it can
  // be served; an RX data read with nothing buffered simply waits there.
  assign status = {28'd0, tx_full, tx_empty, rx_full, !rx_empty};
  assign r_go   = (r_state == R_WAIT) && ((r_addr != ADDR_RX) || !rx_empty);
  assign rx_pop = r_go && (r_addr == ADDR_RX);

  always_comb begin
    r_data_nxt = '0;
    r_resp_nxt = RESP_OKAY;
    case (r_addr)
      ADDR_RX:   r_data_nxt = {24'd0, rx_mem[rx_rptr]};
      ADDR_STAT: r_data_nxt = status;
      default:   r_resp_nxt = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      axi_arready <= 1'b1;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi_arvalid) begin
            r_addr      <= axi_araddr[3:0];
            axi_arready <= 1'b0;
            r_state     <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_go) begin
            axi_rdata  <= r_data_nxt;
            axi_rresp  <= r_resp_nxt;
            axi_rvalid <= 1'b1;
            r_state    <= R_RESP;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write side: address and data are captured independently; each ready
  // drops once its channel is held, so a TX-full stall shows both low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      w_addr      <= '0;
      w_byte      <= '0;
      axi_awready <= 1'b1;
      axi_wready  <= 1'b1;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            if (w_addr != ADDR_TX) begin
              axi_bresp  <= RESP_SLVERR;
              axi_bvalid <= 1'b1;
              aw_held    <= 1'b0;
              w_held     <= 1'b0;
              w_state    <= W_RESP;
            end else if (!tx_full) begin
              axi_bresp  <= RESP_OKAY;
              axi_bvalid <= 1'b1;
              aw_held    <= 1'b0;
              w_held     <= 1'b0;
              w_state    <= W_RESP;
            end
          end else begin
            if (axi_awready && axi_awvalid) begin
              aw_held     <= 1'b1;
              w_addr      <= axi_awaddr[3:0];
              axi_awready <= 1'b0;
            end
            if (axi_wready && axi_wvalid) begin
              w_held     <= 1'b1;
              w_byte     <= axi_wdata[7:0];
              axi_wready <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axi_buffer.sv
module tb_uart_axi_buffer;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_axi_buffer #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, want, $time);
    end
  endfunction

  // Reference model: byte queues for the two FIFOs plus the progress of the
  // one outstanding read and the one outstanding write.
  localparam int RD_IDLE = 0, RD_PENDING = 1, RD_ANSWER = 2;
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  int          rd_stage;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  bit          wr_addr_in, wr_data_in, wr_answer;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_byte;
  logic [1:0]  wr_resp;

  function automatic logic [31:0] exp_status(int rxn, int txn);
    return {28'd0, txn == TXD, txn == 0, rxn == RXD, rxn != 0};
  endfunction

  function automatic void model_reset();
    rxq.delete();
    txq.delete();
    rd_stage = RD_IDLE;
    rd_addr = '0;
    rd_data = '0;
    rd_resp = '0;
    wr_addr_in = 0;
    wr_data_in = 0;
    wr_answer = 0;
    wr_addr = '0;
    wr_byte = '0;
    wr_resp = '0;
  endfunction

  function automatic void model_compare();
    chk("arready", axi_arready, rd_stage == RD_IDLE);
    chk("rvalid", axi_rvalid, rd_stage == RD_ANSWER);
    if (rd_stage == RD_ANSWER) begin
      chk("rdata", axi_rdata, rd_data);
      chk("rresp", axi_rresp, rd_resp);
    end
    chk("awready", axi_awready, !wr_answer && !wr_addr_in);
    chk("wready", axi_wready, !wr_answer && !wr_data_in);
    chk("bvalid", axi_bvalid, wr_answer);
    if (wr_answer) chk("bresp", axi_bresp, wr_resp);
    chk("rx_ready", rx_ready, rxq.size() < RXD);
    chk("tx_valid", tx_valid, txq.size() != 0);
    chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
  endfunction

  // Advance the model across the coming clock edge using this cycle's inputs.
  function automatic void model_step();
    int rxn = rxq.size();
    int txn = txq.size();
    bit rx_take = rx_valid && (rxn < RXD);
    bit tx_give = tx_ready && (txn > 0);
    bit bus_pop = 0;
    bit bus_push = 0;
    logic [7:0] push_byte = wr_byte;
    case (rd_stage)
      RD_IDLE: if (axi_arvalid) begin
        rd_addr = axi_araddr[3:0];
        rd_stage = RD_PENDING;
      end
      RD_PENDING: if (rd_addr != 4'h0 || rxn > 0) begin
        rd_resp = 2'b00;
        if (rd_addr == 4'h0) begin
          rd_data = {24'd0, rxq[0]};
          bus_pop = 1;
        end else if (rd_addr == 4'h8) begin
          rd_data = exp_status(rxn, txn);
        end else begin
          rd_data = 32'd0;
          rd_resp = 2'b10;
        end
        rd_stage = RD_ANSWER;
      end
      default: if (axi_rready) rd_stage = RD_IDLE;
    endcase
    if (wr_answer) begin
      if (axi_bready) wr_answer = 0;
    end else if (wr_addr_in && wr_data_in) begin
      if (wr_addr != 4'h4 || txn < TXD) begin
        bus_push = (wr_addr == 4'h4);
        wr_resp = (wr_addr == 4'h4) ? 2'b00 : 2'b10;
        wr_answer = 1;
        wr_addr_in = 0;
        wr_data_in = 0;
      end
    end else begin
      if (!wr_addr_in && axi_awvalid) begin
        wr_addr_in = 1;
        wr_addr = axi_awaddr[3:0];
      end
      if (!wr_data_in && axi_wvalid) begin
        wr_data_in = 1;
        wr_byte = axi_wdata[7:0];
      end
    end
    if (bus_pop) void'(rxq.pop_front());
    if (rx_take) rxq.push_back(rx_data);
    if (tx_give) void'(txq.pop_front());
    if (bus_push) txq.push_back(push_byte);
  endfunction

  always @(negedge clk) begin
    if (!rstn) model_reset();
    model_compare();
    if (rstn) model_step();
  end

  // Bus tasks start and end just after a rising edge.
  task automatic axi_read(input logic [31:0] addr, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
    bit ok = 0;
    data = 'x;
    resp = 'x;
    lat = 0;
    axi_araddr = addr;
    axi_arvalid = 1'b1;
    axi_rready = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = axi_arready;
    end
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    chk("ar_handshake", ok, 1);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      lat++;
      ok = axi_rvalid;
    end
    chk("r_arrived", ok, 1);
    if (!ok) begin
      @(posedge clk); #1;
      return;
    end
    data = axi_rdata;
    resp = axi_rresp;
    for (int i = 0; i <= rdly; i++) begin
      @(posedge clk); #1;
    end
    axi_rready = 1'b1;
    @(posedge clk); #1;
    axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int awd, input int wd, input int bdly,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, got = 0;
    resp = 2'b11;
    axi_bready = 1'b0;
    axi_awaddr = addr;
    axi_wdata = data;
    axi_wstrb = 4'($urandom);
    for (int c = 0; c < 600 && !got; c++) begin
      if (!aw_done) axi_awvalid = (c >= awd);
      if (!w_done) axi_wvalid = (c >= wd);
      @(negedge clk);
      if (axi_awvalid && axi_awready) aw_done = 1;
      if (axi_wvalid && axi_wready) w_done = 1;
      if (axi_bvalid) begin
        got = 1;
        resp = axi_bresp;
      end
      @(posedge clk); #1;
      if (aw_done) axi_awvalid = 1'b0;
      if (w_done) axi_wvalid = 1'b0;
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    chk("b_arrived", got, 1);
    if (!got) return;
    for (int i = 0; i < bdly; i++) begin
      @(posedge clk); #1;
    end
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  bit stop_drv = 0;

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int lat;
    int acc;

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_arready", axi_arready, 1);
    chk("rst_awready", axi_awready, 1);
    chk("rst_wready", axi_wready, 1);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_tx", {tx_valid, tx_data}, 9'h000);
    chk("rst_rx_ready", rx_ready, 1);
    @(posedge clk); #1;

    // Two received bytes come out in order; status then shows RX empty, TX empty.
    rx_valid = 1'b1; rx_data = 8'h41;
    @(posedge clk); #1;
    rx_data = 8'h42;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    axi_read(32'h7F00_0000, 0, d, r, lat);
    chk("t1_rd0", d, 32'h41);
    chk("t1_resp0", r, 2'b00);
    chk("t1_latency", lat, 2);
    axi_read(32'h7F00_0000, 1, d, r, lat);
    chk("t1_rd1", d, 32'h42);
    axi_read(32'h7F00_0008, 0, d, r, lat);
    chk("t1_status", d, 32'h04);

    // Read of an empty RX port waits until a byte arrives.
    axi_araddr = 32'h7F00_0000;
    axi_arvalid = 1'b1;
    @(negedge clk);
    chk("t2_arready", axi_arready, 1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_stall_rvalid", axi_rvalid, 0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("t2_rvalid_push_cycle", axi_rvalid, 0);
    @(negedge clk);
    chk("t2_rvalid", axi_rvalid, 1);
    chk("t2_rdata", axi_rdata, 32'h55);
    @(posedge clk); #1;
    axi_rready = 1'b1;
    @(posedge clk); #1;
    axi_rready = 1'b0;

    // Unmapped read direction.
    axi_read(32'h0000_0004, 0, d, r, lat);
    chk("rd_tx_resp", r, 2'b10);
    chk("rd_tx_data", d, 32'h0);

    // Single TX write, then drain.
    axi_write(32'h7F00_0004, 32'h1A3, 0, 0, 0, r);
    chk("t3_bresp", r, 2'b00);
    @(negedge clk);
    chk("t3_tx", {tx_valid, tx_data}, 9'h1A3);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("t3_tx_drop", tx_valid, 0);
    @(posedge clk); #1;

    // Fill TX, stall a 17th write, release it with a one-cycle pop.
    for (int i = 0; i < TXD; i++) begin
      axi_write(32'h7F00_0004, 32'h80 + i, i % 3, (i + 1) % 3, 0, r);
      chk("t4_fill_bresp", r, 2'b00);
    end
    fork
      begin
        axi_write(32'h7F00_0004, 32'h90, 0, 0, 0, r);
        chk("t4_17th_bresp", r, 2'b00);
      end
      begin
        repeat (10) @(negedge clk);
        chk("t4_stall", {axi_awready, axi_wready, axi_bvalid}, 3'b000);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
      end
    join
    axi_read(32'h7F00_0008, 0, d, r, lat);
    chk("t4_status_full", d, 32'h08);
    @(negedge clk);
    chk("t4_head", tx_data, 8'h81);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tx_ready = 1'b0;

    // Hold rx_valid across 17 distinct bytes; 16 fit, order survives the wrap.
    acc = 0;
    rx_valid = 1'b1;
    rx_data = 8'h60;
    for (int i = 0; i < 60 && acc < RXD; i++) begin
      @(negedge clk);
      if (rx_ready) acc++;
      @(posedge clk); #1;
      rx_data = 8'h60 + 8'(acc);
    end
    chk("t5_accepted", acc, RXD);
    repeat (3) @(negedge clk);
    chk("t5_rx_ready_low", rx_ready, 0);
    @(posedge clk); #1;
    axi_read(32'h7F00_0008, 0, d, r, lat);
    chk("t5_status", d, 32'h07);
    rx_valid = 1'b0;
    for (int i = 0; i < RXD; i++) begin
      axi_read(32'h7F00_0000, i % 2, d, r, lat);
      chk("t5_pop", d, 32'h60 + i);
    end

    // Late W to an unmapped address, then reset during a stalled read.
    axi_write(32'h7F00_000C, 32'h77, 0, 3, 1, r);
    chk("t6_bresp", r, 2'b10);
    axi_read(32'h7F00_0008, 0, d, r, lat);
    chk("t6_status", d, 32'h04);
    axi_araddr = 32'h7F00_0000;
    axi_arvalid = 1'b1;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("t6_rst_rvalid", axi_rvalid, 0);
    chk("t6_rst_arready", axi_arready, 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    axi_read(32'h7F00_0008, 0, d, r, lat);
    chk("t6_post_rst_status", d, 32'h04);

    // Randomized traffic on all four streams at once.
    fork
      begin
        fork
          begin
            logic [31:0] ra[6];
            logic [31:0] a, rd_d;
            logic [1:0] rd_r;
            int rd_l;
            ra = '{32'h0, 32'h0, 32'h0, 32'h8, 32'h4, 32'hC};
            for (int k = 0; k < 150; k++) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              #1;
              a = ra[$urandom_range(0, 5)];
              a = {$urandom, 4'h0} | {28'd0, a[3:0]};
              axi_read(a, $urandom_range(0, 2), rd_d, rd_r, rd_l);
            end
          end
          begin
            logic [31:0] wa[6];
            logic [31:0] a;
            logic [1:0] wr_r;
            wa = '{32'h4, 32'h4, 32'h4, 32'h0, 32'h8, 32'hC};
            for (int k = 0; k < 150; k++) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              #1;
              a = wa[$urandom_range(0, 5)];
              a = {$urandom, 4'h0} | {28'd0, a[3:0]};
              axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 2), wr_r);
            end
          end
        join
        stop_drv = 1;
      end
      begin
        while (!stop_drv) begin
          @(posedge clk); #1;
          rx_valid = ($urandom_range(0, 2) == 0);
          rx_data = 8'($urandom);
          tx_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
